// File: rtl/tournament_bp.sv
`default_nettype none
// ============================================================================
// Module   : tournament_bp
// Purpose  : Tournament branch predictor for the fetch stage. It has three
//            predictor tables:
//              - a per-PC local bimodal counter table
//              - a gshare counter table, indexed by GHR ^ PC
//              - a per-PC meta chooser table that picks local or gshare
//            A tagged, direct-mapped BTB supplies targets and marks JALs.
//            The global history register is speculative: fetch shifts it,
//            and a retiring mispredict restores it from the ROB snapshot.
//            All tables train at commit.
// Ports    : clk, rst                 clock, synchronous active-high reset
//            fetch_valid, fetch_pc    lookup request (outputs are always live)
//            pred_taken/target/hit    combinational prediction for fetch_pc
//            pred_ghr                 history used by this lookup (to the ROB)
//            cm_*                     retiring control-flow instruction
// Revision : 1.0  initial release
// ============================================================================
module tournament_bp #(
  parameter int BTB_BITS  = 8,
  parameter int LOC_BITS  = 8,
  parameter int GHR_BITS  = 10,
  parameter int CTR_BITS  = 2,
  parameter int META_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_valid,
  input  logic [31:0]         fetch_pc,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  output logic                pred_hit,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                cm_valid,
  input  logic                cm_is_br,
  input  logic                cm_is_jal,
  input  logic [31:0]         cm_pc,
  input  logic                cm_taken,
  input  logic [31:0]         cm_target,
  input  logic [GHR_BITS-1:0] cm_ghr,
  input  logic                cm_mispredict
);

  localparam int BTB_N = 1 << BTB_BITS;
  localparam int LOC_N = 1 << LOC_BITS;
  localparam int GSH_N = 1 << GHR_BITS;
  localparam int TAG_W = 30 - BTB_BITS;

  // Weakly not-taken / weakly local reset values: MSB clear, all other bits set.
  localparam logic [CTR_BITS-1:0]  C_CTR_INIT  = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0]  C_CTR_MAX   = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0]  C_CTR_ZERO  = '0;
  localparam logic [CTR_BITS-1:0]  C_CTR_ONE   = {{(CTR_BITS-1){1'b0}}, 1'b1};
  localparam logic [META_BITS-1:0] C_META_INIT = {1'b0, {(META_BITS-1){1'b1}}};
  localparam logic [META_BITS-1:0] C_META_MAX  = {META_BITS{1'b1}};
  localparam logic [META_BITS-1:0] C_META_ZERO = '0;
  localparam logic [META_BITS-1:0] C_META_ONE  = {{(META_BITS-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic                 r_btb_valid  [BTB_N];
  logic [TAG_W-1:0]     r_btb_tag    [BTB_N];
  logic [31:0]          r_btb_target [BTB_N];
  logic                 r_btb_jal    [BTB_N];
  logic [CTR_BITS-1:0]  r_loc_ctr    [LOC_N];
  logic [META_BITS-1:0] r_meta       [LOC_N];
  logic [CTR_BITS-1:0]  r_gsh_ctr    [GSH_N];
  logic [GHR_BITS-1:0]  r_ghr;

  // --------------------------------------------------------------------------
  // Fetch lookup (combinational)
  // --------------------------------------------------------------------------
  logic [BTB_BITS-1:0] w_f_btb_idx;
  logic [TAG_W-1:0]    w_f_tag;
  logic [LOC_BITS-1:0] w_f_loc_idx;
  logic [GHR_BITS-1:0] w_f_gsh_idx;
  logic                w_f_hit;
  logic                w_f_jal;
  logic                w_f_dir;

  assign w_f_btb_idx = fetch_pc[BTB_BITS+1:2];
  assign w_f_tag     = fetch_pc[31:BTB_BITS+2];
  assign w_f_loc_idx = fetch_pc[LOC_BITS+1:2];
  assign w_f_gsh_idx = r_ghr ^ fetch_pc[GHR_BITS+1:2];

  assign w_f_hit = r_btb_valid[w_f_btb_idx] && (r_btb_tag[w_f_btb_idx] == w_f_tag);
  assign w_f_jal = r_btb_jal[w_f_btb_idx];
  assign w_f_dir = r_meta[w_f_loc_idx][META_BITS-1] ? r_gsh_ctr[w_f_gsh_idx][CTR_BITS-1]
                                                    : r_loc_ctr[w_f_loc_idx][CTR_BITS-1];

  assign pred_hit    = w_f_hit;
  assign pred_taken  = w_f_hit && (w_f_jal || w_f_dir);
  assign pred_target = pred_taken ? r_btb_target[w_f_btb_idx] : (fetch_pc + 32'd4);
  assign pred_ghr    = r_ghr;

  // --------------------------------------------------------------------------
  // Commit-side indices and pre-update counter values
  // --------------------------------------------------------------------------
  logic [BTB_BITS-1:0]  w_c_btb_idx;
  logic [TAG_W-1:0]     w_c_tag;
  logic [LOC_BITS-1:0]  w_c_loc_idx;
  logic [GHR_BITS-1:0]  w_c_gsh_idx;
  logic [CTR_BITS-1:0]  w_c_loc_ctr;
  logic [CTR_BITS-1:0]  w_c_gsh_ctr;
  logic [META_BITS-1:0] w_c_meta;
  logic                 w_c_loc_pred;
  logic                 w_c_gsh_pred;
  logic                 w_train;
  logic                 w_alloc;
  logic [CTR_BITS-1:0]  w_loc_next;
  logic [CTR_BITS-1:0]  w_gsh_next;
  logic [META_BITS-1:0] w_meta_next;

  assign w_c_btb_idx  = cm_pc[BTB_BITS+1:2];
  assign w_c_tag      = cm_pc[31:BTB_BITS+2];
  assign w_c_loc_idx  = cm_pc[LOC_BITS+1:2];
  assign w_c_gsh_idx  = cm_ghr ^ cm_pc[GHR_BITS+1:2];
  assign w_c_loc_ctr  = r_loc_ctr[w_c_loc_idx];
  assign w_c_gsh_ctr  = r_gsh_ctr[w_c_gsh_idx];
  assign w_c_meta     = r_meta[w_c_loc_idx];
  assign w_c_loc_pred = w_c_loc_ctr[CTR_BITS-1];
  assign w_c_gsh_pred = w_c_gsh_ctr[CTR_BITS-1];

  assign w_train = cm_valid && cm_is_br;
  assign w_alloc = cm_valid && ((cm_is_br && cm_taken) || cm_is_jal);

  always_comb begin
    w_loc_next = w_c_loc_ctr;
    if (cm_taken && (w_c_loc_ctr != C_CTR_MAX))        w_loc_next = w_c_loc_ctr + C_CTR_ONE;
    else if (!cm_taken && (w_c_loc_ctr != C_CTR_ZERO)) w_loc_next = w_c_loc_ctr - C_CTR_ONE;
  end

  always_comb begin
    w_gsh_next = w_c_gsh_ctr;
    if (cm_taken && (w_c_gsh_ctr != C_CTR_MAX))        w_gsh_next = w_c_gsh_ctr + C_CTR_ONE;
    else if (!cm_taken && (w_c_gsh_ctr != C_CTR_ZERO)) w_gsh_next = w_c_gsh_ctr - C_CTR_ONE;
  end

  // The chooser only learns when the two components disagree; then exactly
  // one of them was right and the counter moves toward that one.
  always_comb begin
    w_meta_next = w_c_meta;
    if (w_c_loc_pred != w_c_gsh_pred) begin
      if ((w_c_gsh_pred == cm_taken) && (w_c_meta != C_META_MAX))
        w_meta_next = w_c_meta + C_META_ONE;
      else if ((w_c_loc_pred == cm_taken) && (w_c_meta != C_META_ZERO))
        w_meta_next = w_c_meta - C_META_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Speculative GHR: a mispredict restore wins over a same-cycle fetch shift.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (cm_valid && cm_mispredict && cm_is_br) begin
      r_ghr <= {cm_ghr[GHR_BITS-2:0], cm_taken};
    end else if (cm_valid && cm_mispredict && cm_is_jal) begin
      r_ghr <= cm_ghr;
    end else if (fetch_valid && w_f_hit && !w_f_jal) begin
      r_ghr <= {r_ghr[GHR_BITS-2:0], pred_taken};
    end
  end

  // --------------------------------------------------------------------------
  // Table updates. No read bypass: a same-cycle fetch sees the old contents.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_N; i++) r_btb_valid[i] <= 1'b0;
    end else if (w_alloc) begin
      r_btb_valid[w_c_btb_idx] <= 1'b1;
    end
  end

  // Payload fields are qualified by the valid bit and need no reset.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_btb_tag[w_c_btb_idx]    <= w_c_tag;
      r_btb_target[w_c_btb_idx] <= cm_target;
      r_btb_jal[w_c_btb_idx]    <= cm_is_jal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LOC_N; i++) begin
        r_loc_ctr[i] <= C_CTR_INIT;
        r_meta[i]    <= C_META_INIT;
      end
    end else if (w_train) begin
      r_loc_ctr[w_c_loc_idx] <= w_loc_next;
      r_meta[w_c_loc_idx]    <= w_meta_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < GSH_N; i++) r_gsh_ctr[i] <= C_CTR_INIT;
    end else if (w_train) begin
      r_gsh_ctr[w_c_gsh_idx] <= w_gsh_next;
    end
  end

  // Byte-offset bits of the PCs play no part in indexing or tagging.
  logic w_unused;
  assign w_unused = ^{fetch_pc[1:0], cm_pc[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_tournament_bp.sv
`default_nettype none
// ============================================================================
// Module   : tb_tournament_bp
// Purpose  : Directed scoreboard bench for tournament_bp. Each fetch pushes
//            its hand-computed prediction into a queue; a monitor pops and
//            compares on the falling edge of every cycle with fetch_valid.
// Revision : 1.0  initial release
// ============================================================================
module tb_tournament_bp;

  localparam int GHR_BITS = 10;

  logic                clk = 1'b0;
  logic                rst;
  logic                fetch_valid;
  logic [31:0]         fetch_pc;
  logic                pred_taken;
  logic [31:0]         pred_target;
  logic                pred_hit;
  logic [GHR_BITS-1:0] pred_ghr;
  logic                cm_valid;
  logic                cm_is_br;
  logic                cm_is_jal;
  logic [31:0]         cm_pc;
  logic                cm_taken;
  logic [31:0]         cm_target;
  logic [GHR_BITS-1:0] cm_ghr;
  logic                cm_mispredict;

  tournament_bp #(
    .BTB_BITS (8),
    .LOC_BITS (8),
    .GHR_BITS (GHR_BITS),
    .CTR_BITS (2),
    .META_BITS(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_valid  (fetch_valid),
    .fetch_pc     (fetch_pc),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target),
    .pred_hit     (pred_hit),
    .pred_ghr     (pred_ghr),
    .cm_valid     (cm_valid),
    .cm_is_br     (cm_is_br),
    .cm_is_jal    (cm_is_jal),
    .cm_pc        (cm_pc),
    .cm_taken     (cm_taken),
    .cm_target    (cm_target),
    .cm_ghr       (cm_ghr),
    .cm_mispredict(cm_mispredict)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                hit;
    logic                taken;
    logic [31:0]         target;
    logic [GHR_BITS-1:0] ghr;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   n_tag  = 0;

  // Monitor: one comparison per presented fetch.
  always @(negedge clk) begin
    if (fetch_valid) begin
      exp_t e;
      exp_t a;
      a = '{hit: pred_hit, taken: pred_taken, target: pred_target, ghr: pred_ghr};
      n_vec++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL fetch_%0d: no expectation queued, got hit=%0b taken=%0b tgt=%h ghr=%h",
                 n_vec, a.hit, a.taken, a.target, a.ghr);
      end else begin
        e = sb_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL fetch_%0d pc=%h: got hit=%0b taken=%0b tgt=%h ghr=%h, expected hit=%0b taken=%0b tgt=%h ghr=%h",
                   n_vec, fetch_pc, a.hit, a.taken, a.target, a.ghr,
                   e.hit, e.taken, e.target, e.ghr);
        end
      end
    end
  end

  // All tasks start and end at posedge+1.
  task automatic tick();
    @(posedge clk);
    #1;
    fetch_valid   = 1'b0;
    cm_valid      = 1'b0;
    cm_is_br      = 1'b0;
    cm_is_jal     = 1'b0;
    cm_mispredict = 1'b0;
  endtask

  task automatic fetch_set(input logic [31:0] pc, input logic hit, input logic taken,
                           input logic [31:0] tgt, input logic [GHR_BITS-1:0] ghr);
    exp_t e;
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    e = '{hit: hit, taken: taken, target: tgt, ghr: ghr};
    sb_q.push_back(e);
    n_tag++;
  endtask

  task automatic commit_set(input logic is_br, input logic is_jal, input logic [31:0] pc,
                            input logic taken, input logic [31:0] tgt,
                            input logic [GHR_BITS-1:0] ghr, input logic mis);
    cm_valid      = 1'b1;
    cm_is_br      = is_br;
    cm_is_jal     = is_jal;
    cm_pc         = pc;
    cm_taken      = taken;
    cm_target     = tgt;
    cm_ghr        = ghr;
    cm_mispredict = mis;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic hit, input logic taken,
                       input logic [31:0] tgt, input logic [GHR_BITS-1:0] ghr);
    fetch_set(pc, hit, taken, tgt, ghr);
    tick();
  endtask

  task automatic commit(input logic is_br, input logic is_jal, input logic [31:0] pc,
                        input logic taken, input logic [31:0] tgt,
                        input logic [GHR_BITS-1:0] ghr, input logic mis);
    commit_set(is_br, is_jal, pc, taken, tgt, ghr, mis);
    tick();
  endtask

  // Force the GHR through a mispredicted JAL retiring at an unrelated PC.
  task automatic set_ghr(input logic [GHR_BITS-1:0] v);
    commit(1'b0, 1'b1, 32'h3004, 1'b1, 32'h3010, v, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    logic [GHR_BITS-1:0] h;
    logic                t;
    rst = 1'b1;
    fetch_valid = 1'b0; fetch_pc = 32'h0;
    cm_valid = 1'b0; cm_is_br = 1'b0; cm_is_jal = 1'b0; cm_pc = 32'h0;
    cm_taken = 1'b0; cm_target = 32'h0; cm_ghr = '0; cm_mispredict = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    fetch(32'h1000, 1'b0, 1'b0, 32'h1004, 10'h000);

    // JAL allocates and predicts taken; no GHR shift
    commit(1'b0, 1'b1, 32'h1000, 1'b1, 32'h2000, 10'h000, 1'b0);
    fetch(32'h1000, 1'b1, 1'b1, 32'h2000, 10'h000);
    fetch(32'h1000, 1'b1, 1'b1, 32'h2000, 10'h000);

    // Taken twice -> predicts taken; GHR then shifts to 1
    repeat (2) commit(1'b1, 1'b0, 32'h1100, 1'b1, 32'h1040, 10'h000, 1'b0);
    fetch(32'h1100, 1'b1, 1'b1, 32'h1040, 10'h000);
    // Not-taken twice -> still a hit, falls through; GHR then shifts to 2
    repeat (2) commit(1'b1, 1'b0, 32'h1100, 1'b0, 32'h1040, 10'h000, 1'b0);
    fetch(32'h1100, 1'b1, 1'b0, 32'h1104, 10'h001);

    // Alternating T,N,... with the branch's own history as cm_ghr
    h = '0;
    for (int k = 0; k < 64; k++) begin
      t = ((k % 2) == 0);
      commit(1'b1, 1'b0, 32'h2200, t, 32'h2400, h, 1'b0);
      h = {h[GHR_BITS-2:0], t};
    end
    // Local counter sits at 1 (not-taken); gshare must be chosen to get taken
    set_ghr(10'h2AA);
    fetch(32'h2200, 1'b1, 1'b1, 32'h2400, 10'h2AA);
    fetch(32'h2200, 1'b1, 1'b0, 32'h2204, 10'h155);
    fetch(32'h2200, 1'b1, 1'b1, 32'h2400, 10'h2AA);

    // Mispredict restore beats the same-cycle fetch shift
    set_ghr(10'h005);
    fetch_set(32'h1100, 1'b1, 1'b0, 32'h1104, 10'h005);
    commit_set(1'b1, 1'b0, 32'h3008, 1'b1, 32'h3100, 10'h0F0, 1'b1);
    tick();
    fetch(32'h5000, 1'b0, 1'b0, 32'h5004, 10'h1E1);

    // Aliasing at BTB index 0
    set_ghr(10'h000);
    commit(1'b1, 1'b0, 32'h1000, 1'b1, 32'h1080, 10'h000, 1'b0);
    commit(1'b1, 1'b0, 32'h1400, 1'b1, 32'h1480, 10'h000, 1'b0);
    fetch(32'h1000, 1'b0, 1'b0, 32'h1004, 10'h000);
    // Same-cycle overwrite: fetch still sees the old entry
    fetch_set(32'h1400, 1'b1, 1'b1, 32'h1480, 10'h000);
    commit_set(1'b1, 1'b0, 32'h1000, 1'b1, 32'h10C0, 10'h000, 1'b0);
    tick();
    fetch(32'h1400, 1'b0, 1'b0, 32'h1404, 10'h001);
    fetch(32'h1000, 1'b1, 1'b1, 32'h10C0, 10'h001);

    // Commit with neither type bit set is ignored, even with mispredict
    commit(1'b0, 1'b0, 32'h1400, 1'b1, 32'h1480, 10'h3FF, 1'b1);
    fetch(32'h1400, 1'b0, 1'b0, 32'h1404, 10'h003);

    // Mid-stream reset clears BTB and GHR
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fetch(32'h1000, 1'b0, 1'b0, 32'h1004, 10'h000);
    fetch(32'h1100, 1'b0, 1'b0, 32'h1104, 10'h000);
    fetch(32'h2200, 1'b0, 1'b0, 32'h2204, 10'h000);

    tick();
    if (sb_q.size() != 0 || n_vec != n_tag) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, %0d checked of %0d issued",
               sb_q.size(), n_vec, n_tag);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
